// File: rtl/sorter_sel_param.sv
// In-place selection sorter over an N x W single-write-port RAM. The user owns the
// RAM while o_ready is high; i_start runs an ascending/descending (optionally signed) sort.
module sorter_sel_param #(
  parameter  int W      = 8,
  parameter  int N      = 8,
  parameter  int SIGNED = 0,
  localparam int AW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          i_start,
  input  logic          i_desc,
  input  logic          i_wr,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_datain,
  output logic [W-1:0]  o_dataout,
  output logic          o_ready,
  output logic          o_done,
  output logic [AW:0]   o_swaps
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADM,
    S_SCAN,
    S_DECIDE,
    S_SWAPA,
    S_SWAPB
  } state_t;

  localparam logic [AW-1:0] LAST   = AW'(N - 1);
  localparam logic [AW-1:0] PENULT = AW'(N - 2);
  localparam logic [AW-1:0] ONE    = AW'(1);
  localparam logic [AW:0]   DEPTH  = (AW+1)'(N);

  if (N < 2) begin : g_bad_n
    $error("sorter_sel_param: N must be at least 2");
  end

  state_t        r_state, w_state_next;
  logic [AW-1:0] r_i, w_i_next;
  logic [AW-1:0] r_j, w_j_next;
  logic [AW-1:0] r_jm, w_jm_next;
  logic [W-1:0]  r_m, w_m_next;
  logic [W-1:0]  r_ai, w_ai_next;
  logic          r_desc, w_desc_next;
  logic [AW:0]   r_swaps, w_swaps_next;
  logic          r_done;
  logic [W-1:0]  r_dataout;
  logic [W-1:0]  r_mem [N];

  logic          w_addr_ok;
  logic          w_gt, w_lt, w_better;
  logic          w_advance;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_addr;
  logic          w_wr_req, w_wr_en;
  logic [AW-1:0] w_wr_addr;
  logic [W-1:0]  w_wr_data;

  assign w_addr_ok = ({1'b0, i_addr} < DEPTH);

  if (SIGNED != 0) begin : g_signed
    assign w_gt = $signed(r_dataout) > $signed(r_m);
    assign w_lt = $signed(r_dataout) < $signed(r_m);
  end else begin : g_unsigned
    assign w_gt = r_dataout > r_m;
    assign w_lt = r_dataout < r_m;
  end

  // Strict comparison: equal keys keep the earlier index as the candidate.
  assign w_better = r_desc ? w_gt : w_lt;

  always_comb begin
    w_state_next = r_state;
    w_i_next     = r_i;
    w_j_next     = r_j;
    w_jm_next    = r_jm;
    w_m_next     = r_m;
    w_ai_next    = r_ai;
    w_desc_next  = r_desc;
    w_swaps_next = r_swaps;
    w_advance    = 1'b0;
    w_rd_en      = 1'b0;
    w_rd_addr    = '0;
    w_wr_req     = 1'b0;
    w_wr_addr    = '0;
    w_wr_data    = '0;

    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_desc_next  = i_desc;
          w_swaps_next = '0;
          w_i_next     = '0;
          w_rd_en      = 1'b1;
          w_rd_addr    = '0;
          w_state_next = S_LOADM;
        end else begin
          w_rd_en   = w_addr_ok;
          w_rd_addr = i_addr;
          w_wr_req  = i_wr & w_addr_ok;
          w_wr_addr = i_addr;
          w_wr_data = i_datain;
        end
      end
      S_LOADM: begin
        w_m_next     = r_dataout;
        w_ai_next    = r_dataout;
        w_jm_next    = r_i;
        w_j_next     = r_i + ONE;
        w_rd_en      = 1'b1;
        w_rd_addr    = r_i + ONE;
        w_state_next = S_SCAN;
      end
      S_SCAN: begin
        if (w_better) begin
          w_m_next  = r_dataout;
          w_jm_next = r_j;
        end
        if (r_j == LAST) begin
          w_state_next = S_DECIDE;
        end else begin
          w_j_next  = r_j + ONE;
          w_rd_en   = 1'b1;
          w_rd_addr = r_j + ONE;
        end
      end
      S_DECIDE: begin
        if (r_jm == r_i) w_advance = 1'b1;
        else             w_state_next = S_SWAPA;
      end
      S_SWAPA: begin
        w_wr_req     = 1'b1;
        w_wr_addr    = r_jm;
        w_wr_data    = r_ai;
        w_state_next = S_SWAPB;
      end
      S_SWAPB: begin
        w_wr_req     = 1'b1;
        w_wr_addr    = r_i;
        w_wr_data    = r_m;
        w_swaps_next = r_swaps + 1'b1;
        w_advance    = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_advance) begin
      if (r_i == PENULT) begin
        w_state_next = S_IDLE;
      end else begin
        w_i_next     = r_i + ONE;
        w_rd_en      = 1'b1;
        w_rd_addr    = r_i + ONE;
        w_state_next = S_LOADM;
      end
    end
  end

  // Gating with nrst keeps a write from landing once reset has been asserted.
  assign w_wr_en = w_wr_req & nrst;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_dataout <= '0;
    else       r_dataout <= w_rd_en ? r_mem[w_rd_addr] : '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_jm    <= '0;
      r_m     <= '0;
      r_ai    <= '0;
      r_desc  <= 1'b0;
      r_swaps <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_i     <= w_i_next;
      r_j     <= w_j_next;
      r_jm    <= w_jm_next;
      r_m     <= w_m_next;
      r_ai    <= w_ai_next;
      r_desc  <= w_desc_next;
      r_swaps <= w_swaps_next;
      r_done  <= (r_state != S_IDLE) && (w_state_next == S_IDLE);
    end
  end

  assign o_dataout = r_dataout;
  assign o_ready   = (r_state == S_IDLE);
  assign o_done    = r_done;
  assign o_swaps   = r_swaps;

endmodule

// File: tb/tb_sorter_sel_param.sv
// Drives an unsigned 8-bit sorter and a signed 4-bit sorter with shared stimulus and
// checks sorted contents, swap counts, busy latency and the done pulse.
module tb_sorter_sel_param;
  localparam int N     = 8;
  localparam int TBASE = 2 * (N - 1) + N * (N - 1) / 2;
  localparam int NVEC  = 5;

  typedef struct packed {
    logic [7:0][7:0] d;
    logic [7:0][7:0] e;
    logic            dsc;
    logic            noise;
    logic            wrs;
    logic [3:0]      sw;
  } vec_t;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start = 1'b0;
  logic       desc = 1'b0;
  logic       wr = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] datain = '0;
  logic [7:0] dout8;
  logic [3:0] dout4;
  logic       rdy8, rdy4, done8, done4;
  logic [3:0] sw8, sw4;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] load_vals [N];
  logic [7:0] exp8 [N];
  logic [3:0] exp4 [N];
  int         exp_sw8, exp_sw4;
  int         m_val [N];
  vec_t       tbl [NVEC];

  always #5 clk = ~clk;

  sorter_sel_param #(.W(8), .N(8), .SIGNED(0)) dut (
    .clk(clk), .nrst(nrst), .i_start(start), .i_desc(desc), .i_wr(wr),
    .i_addr(addr), .i_datain(datain), .o_dataout(dout8), .o_ready(rdy8),
    .o_done(done8), .o_swaps(sw8)
  );

  sorter_sel_param #(.W(4), .N(8), .SIGNED(1)) dut_s (
    .clk(clk), .nrst(nrst), .i_start(start), .i_desc(desc), .i_wr(wr),
    .i_addr(addr), .i_datain(datain[3:0]), .o_dataout(dout4), .o_ready(rdy4),
    .o_done(done4), .o_swaps(sw4)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0][7:0] pk8(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7);
    logic [7:0][7:0] r;
    r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
    r[4] = 8'(a4); r[5] = 8'(a5); r[6] = 8'(a6); r[7] = 8'(a7);
    return r;
  endfunction

  // Numeric value of the low w bits, as two's complement when sgn is set.
  function automatic int key(input int v, input int w, input bit sgn);
    int x;
    x = v & ((1 << w) - 1);
    if (sgn && x >= (1 << (w - 1))) x = x - (1 << w);
    return x;
  endfunction

  // Reference: place the best remaining key at each position, first occurrence on ties.
  task automatic model(input int w, input bit sgn, input bit dsc, output int sw);
    int best, kb, kbest, t;
    sw = 0;
    for (int a = 0; a < N - 1; a++) begin
      best = a;
      for (int b = a + 1; b < N; b++) begin
        kb    = key(m_val[b], w, sgn);
        kbest = key(m_val[best], w, sgn);
        if (dsc ? (kb > kbest) : (kb < kbest)) best = b;
      end
      if (best != a) begin
        t = m_val[a]; m_val[a] = m_val[best]; m_val[best] = t;
        sw++;
      end
    end
  endtask

  task automatic load_ram();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      wr = 1'b1; addr = 3'(k); datain = load_vals[k];
    end
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic do_sort(input string tag, input bit dsc, input bit do_load,
                         input bit wr_start, input bit noise);
    int t8, t4, d8, d4;
    bit seen8, seen4;
    for (int k = 0; k < N; k++) m_val[k] = int'(load_vals[k]);
    model(4, 1'b1, dsc, exp_sw4);
    for (int k = 0; k < N; k++) exp4[k] = 4'(m_val[k]);

    if (do_load) load_ram();
    else @(negedge clk);
    check({tag, " ready8_idle"}, int'(rdy8), 1);
    check({tag, " ready4_idle"}, int'(rdy4), 1);
    start = 1'b1; desc = dsc; wr = wr_start; addr = 3'd2; datain = 8'h00;

    t8 = 0; t4 = 0; d8 = 0; d4 = 0; seen8 = 1'b0; seen4 = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin start = 1'b0; wr = 1'b0; end
      d8 += int'(done8);
      d4 += int'(done4);
      if (!seen8) begin
        if (rdy8) begin seen8 = 1'b1; check({tag, " done8_first_ready"}, int'(done8), 1); end
        else t8++;
      end
      if (!seen4) begin
        if (rdy4) begin seen4 = 1'b1; check({tag, " done4_first_ready"}, int'(done4), 1); end
        else t4++;
      end
      if (noise && c == 3) begin
        start = 1'b1; wr = 1'b1; addr = 3'd0; datain = 8'hAA; desc = ~dsc;
      end
      if (noise && c == 6) begin
        start = 1'b0; wr = 1'b0; desc = dsc;
      end
      if (seen8 && seen4) break;
    end
    @(negedge clk);
    d8 += int'(done8);
    d4 += int'(done4);

    check({tag, " busy8_cycles"}, t8, TBASE + 2 * exp_sw8);
    check({tag, " busy4_cycles"}, t4, TBASE + 2 * exp_sw4);
    check({tag, " swaps8"}, int'(sw8), exp_sw8);
    check({tag, " swaps4"}, int'(sw4), exp_sw4);
    check({tag, " done8_pulses"}, d8, 1);
    check({tag, " done4_pulses"}, d4, 1);

    for (int k = 0; k < N; k++) begin
      addr = 3'(k);
      @(negedge clk);
      check($sformatf("%s mem8[%0d]", tag, k), int'(dout8), int'(exp8[k]));
      check($sformatf("%s mem4[%0d]", tag, k), int'(dout4), int'(exp4[k]));
    end
    $display("sort %s desc=%0d T8=%0d swaps8=%0d T4=%0d swaps4=%0d",
             tag, dsc, t8, sw8, t4, sw4);
  endtask

  initial begin
    tbl[0] = '{d: pk8(5, 3, 7, 1, 8, 2, 6, 4), e: pk8(1, 2, 3, 4, 5, 6, 7, 8),
               dsc: 1'b0, noise: 1'b0, wrs: 1'b0, sw: 4'd6};
    tbl[1] = '{d: pk8(5, 3, 7, 1, 8, 2, 6, 4), e: pk8(8, 7, 6, 5, 4, 3, 2, 1),
               dsc: 1'b1, noise: 1'b1, wrs: 1'b0, sw: 4'd6};
    tbl[2] = '{d: pk8(1, 2, 3, 4, 5, 6, 7, 8), e: pk8(1, 2, 3, 4, 5, 6, 7, 8),
               dsc: 1'b0, noise: 1'b0, wrs: 1'b1, sw: 4'd0};
    tbl[3] = '{d: pk8(9, 9, 9, 9, 9, 9, 9, 9), e: pk8(9, 9, 9, 9, 9, 9, 9, 9),
               dsc: 1'b0, noise: 1'b0, wrs: 1'b0, sw: 4'd0};
    tbl[4] = '{d: pk8(8'hF8, 8'h07, 8'hFF, 8'h00, 8'h03, 8'hFE, 8'h05, 8'h01),
               e: pk8(8'h00, 8'h01, 8'h03, 8'h05, 8'h07, 8'hF8, 8'hFE, 8'hFF),
               dsc: 1'b0, noise: 1'b0, wrs: 1'b0, sw: 4'd6};

    nrst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ready8", int'(rdy8), 1);
    check("reset done8", int'(done8), 0);
    check("reset swaps8", int'(sw8), 0);
    check("reset dout8", int'(dout8), 0);
    check("reset ready4", int'(rdy4), 1);
    check("reset swaps4", int'(sw4), 0);
    nrst = 1'b1;

    for (int v = 0; v < NVEC; v++) begin
      for (int k = 0; k < N; k++) begin
        load_vals[k] = tbl[v].d[k];
        exp8[k]      = tbl[v].e[k];
      end
      exp_sw8 = int'(tbl[v].sw);
      do_sort($sformatf("vec%0d", v), tbl[v].dsc, 1'b1, tbl[v].wrs, tbl[v].noise);
    end

    // Reset during the first scan pass, before any swap can have been written.
    for (int k = 0; k < N; k++) begin
      load_vals[k] = tbl[0].d[k];
      exp8[k]      = tbl[0].e[k];
    end
    exp_sw8 = int'(tbl[0].sw);
    load_ram();
    start = 1'b1; desc = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("midsort ready8", int'(rdy8), 0);
    nrst = 1'b0;
    #1;
    check("abort ready8", int'(rdy8), 1);
    check("abort done8", int'(done8), 0);
    check("abort swaps8", int'(sw8), 0);
    check("abort ready4", int'(rdy4), 1);
    check("abort done4", int'(done4), 0);
    @(negedge clk);
    nrst = 1'b1;
    do_sort("after_abort", 1'b0, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      bit dsc;
      dsc = 1'($urandom_range(0, 1));
      for (int k = 0; k < N; k++)
        load_vals[k] = (r % 2 == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      for (int k = 0; k < N; k++) m_val[k] = int'(load_vals[k]);
      model(8, 1'b0, dsc, exp_sw8);
      for (int k = 0; k < N; k++) exp8[k] = 8'(m_val[k]);
      do_sort($sformatf("rand%0d", r), dsc, 1'b1, 1'b0, (r == 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
